// File: rtl/ucsbece154a_datapath.sv
// ucsbece154a_datapath: multicycle RV32I datapath (PC/OldPC/IR/Data/A/B/ALUOut, 32x32 regfile, ALU, imm extender, muxes)
// Ports: clk, reset (async active-low); control word PCWrite_i, AdrSrc_i, IRWrite_i, RegWrite_i,
//        ALUSrcA_i, ALUSrcB_i, ResultSrc_i, ALUControl_i, ImmSrc_i; memory ReadData_i / Adr_o / WriteData_o;
//        decoded fields op_o, funct3_o, funct7_o and ALU zero flag zero_o back to the controller.
module ucsbece154a_datapath #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite_i,
    input  logic            AdrSrc_i,
    input  logic            IRWrite_i,
    input  logic            RegWrite_i,
    input  logic [1:0]      ALUSrcA_i,
    input  logic [1:0]      ALUSrcB_i,
    input  logic [1:0]      ResultSrc_i,
    input  logic [2:0]      ALUControl_i,
    input  logic [2:0]      ImmSrc_i,
    input  logic [XLEN-1:0] ReadData_i,
    output logic [XLEN-1:0] Adr_o,
    output logic [XLEN-1:0] WriteData_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic            funct7_o,
    output logic            zero_o
);
    logic [XLEN-1:0] r_pc, r_oldpc, r_ir, r_data, r_a, r_b, r_aluout;
    logic [XLEN-1:0] r_rf [32];
    logic [XLEN-1:0] w_imm, w_srca, w_srcb, w_alu, w_result;
    always_comb begin
        w_imm = ImmSrc_i == 3'b000 ? {{20{r_ir[31]}}, r_ir[31:20]} :
                ImmSrc_i == 3'b001 ? {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]} :
                ImmSrc_i == 3'b010 ? {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0} :
                ImmSrc_i == 3'b011 ? {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0} :
                ImmSrc_i == 3'b100 ? {r_ir[31:12], 12'b0} : '0;
        w_srca = ALUSrcA_i == 2'b00 ? r_pc : ALUSrcA_i == 2'b01 ? r_oldpc : ALUSrcA_i == 2'b10 ? r_a : '0;
        w_srcb = ALUSrcB_i == 2'b00 ? r_b : ALUSrcB_i == 2'b01 ? w_imm : ALUSrcB_i == 2'b10 ? XLEN'(4) : '0;
        // signed compare directly, so slt is immune to subtraction overflow
        w_alu = ALUControl_i == 3'b000 ? w_srca + w_srcb :
                ALUControl_i == 3'b001 ? w_srca - w_srcb :
                ALUControl_i == 3'b010 ? w_srca & w_srcb :
                ALUControl_i == 3'b011 ? w_srca | w_srcb :
                ALUControl_i == 3'b101 ? XLEN'($signed(w_srca) < $signed(w_srcb)) : '0;
        w_result = ResultSrc_i == 2'b00 ? r_aluout : ResultSrc_i == 2'b01 ? r_data :
                   ResultSrc_i == 2'b10 ? w_alu : w_imm;
    end
    assign Adr_o       = AdrSrc_i ? w_result : r_pc;
    assign WriteData_o = r_b;
    assign op_o        = r_ir[6:0];
    assign funct3_o    = r_ir[14:12];
    assign funct7_o    = r_ir[30];
    assign zero_o      = w_alu == '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_oldpc  <= '0;
            r_ir     <= '0;
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_data   <= ReadData_i;
            r_a      <= r_rf[r_ir[19:15]];
            r_b      <= r_rf[r_ir[24:20]];
            r_aluout <= w_alu;
            if (IRWrite_i) begin
                r_ir    <= ReadData_i;
                r_oldpc <= r_pc;
            end
            if (PCWrite_i) r_pc <= w_result;
            // x0 is never written, so it reads 0 without a read-side mux
            if (RegWrite_i && r_ir[11:7] != 5'd0) r_rf[r_ir[11:7]] <= w_result;
        end
    end
endmodule

// File: tb/tb_ucsbece154a_datapath.sv
// tb_ucsbece154a_datapath: directed-vector bench for the multicycle RV32I datapath
module tb_ucsbece154a_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite_i, AdrSrc_i, IRWrite_i, RegWrite_i;
    logic [1:0]  ALUSrcA_i, ALUSrcB_i, ResultSrc_i;
    logic [2:0]  ALUControl_i, ImmSrc_i;
    logic [31:0] ReadData_i, Adr_o, WriteData_o;
    logic [6:0]  op_o;
    logic [2:0]  funct3_o;
    logic        funct7_o, zero_o;
    int tests = 0;
    int fails = 0;

    ucsbece154a_datapath dut (
        .clk(clk), .reset(reset), .PCWrite_i(PCWrite_i), .AdrSrc_i(AdrSrc_i), .IRWrite_i(IRWrite_i),
        .RegWrite_i(RegWrite_i), .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i), .ResultSrc_i(ResultSrc_i),
        .ALUControl_i(ALUControl_i), .ImmSrc_i(ImmSrc_i), .ReadData_i(ReadData_i), .Adr_o(Adr_o),
        .WriteData_o(WriteData_o), .op_o(op_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic pcw, adr, irw, rw, input logic [1:0] sa, sb, rs, input logic [2:0] ac, is);
        PCWrite_i = pcw; AdrSrc_i = adr; IRWrite_i = irw; RegWrite_i = rw;
        ALUSrcA_i = sa; ALUSrcB_i = sb; ResultSrc_i = rs; ALUControl_i = ac; ImmSrc_i = is;
    endtask

    task automatic fetch(input logic [31:0] w);
        ReadData_i = w;
        ctrl(1, 0, 1, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
        step();
    endtask

    task automatic decode();
        ctrl(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b010);
        step();
    endtask

    task automatic exec_i();
        ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000);
        step();
    endtask

    task automatic alu_wb();
        ctrl(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        step();
    endtask

    task automatic run_addi(input logic [31:0] w);
        fetch(w);
        decode();
        exec_i();
        alu_wb();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ReadData_i = 32'hBAD0_C0DE;
        ctrl(1, 0, 1, 1, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
        repeat (3) step();
        ctrl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        #1;
        tests++; if (Adr_o !== 32'h0) begin fails++; $display("FAIL reset_adr: got %h expected %h", Adr_o, 32'h0); end
        tests++; if (op_o !== 7'h0 || funct3_o !== 3'h0 || funct7_o !== 1'b0) begin fails++; $display("FAIL reset_fields: got op=%h f3=%h f7=%b expected 0", op_o, funct3_o, funct7_o); end
        tests++; if (WriteData_o !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h expected %h", WriteData_o, 32'h0); end
        tests++; if (zero_o !== 1'b1) begin fails++; $display("FAIL reset_zero: got %b expected 1", zero_o); end
        tests++; if (dut.r_ir !== 32'h0) begin fails++; $display("FAIL reset_ir: got %h expected %h", dut.r_ir, 32'h0); end
        reset = 1'b1;
    endtask

    task automatic test_fetch_addi();
        tests++; if (Adr_o !== 32'h0) begin fails++; $display("FAIL fetch_adr0: got %h expected %h", Adr_o, 32'h0); end
        fetch(32'h0050_0093);
        tests++; if (Adr_o !== 32'h4) begin fails++; $display("FAIL fetch_pc4: got %h expected %h", Adr_o, 32'h4); end
        tests++; if (op_o !== 7'h13 || funct3_o !== 3'h0) begin fails++; $display("FAIL fetch_op: got op=%h f3=%h expected op=13 f3=0", op_o, funct3_o); end
        tests++; if (dut.r_ir !== 32'h0050_0093) begin fails++; $display("FAIL fetch_ir: got %h expected %h", dut.r_ir, 32'h0050_0093); end
        decode();
        ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000);
        #1;
        tests++; if (zero_o !== 1'b0) begin fails++; $display("FAIL addi_zero: got %b expected 0", zero_o); end
        step();
        alu_wb();
        tests++; if (dut.r_rf[1] !== 32'h5) begin fails++; $display("FAIL addi_rf1: got %h expected %h", dut.r_rf[1], 32'h5); end
    endtask

    task automatic test_no_bypass();
        run_addi(32'h0030_8093);
        tests++; if (dut.r_rf[1] !== 32'h8) begin fails++; $display("FAIL nobyp_rf1: got %h expected %h", dut.r_rf[1], 32'h8); end
        ctrl(0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000);
        #1;
        tests++; if (Adr_o !== 32'h8) begin fails++; $display("FAIL nobyp_a: got %h expected %h", Adr_o, 32'h8); end
    endtask

    task automatic test_lw();
        run_addi(32'h1000_0113);
        tests++; if (dut.r_rf[2] !== 32'h100) begin fails++; $display("FAIL lw_rf2: got %h expected %h", dut.r_rf[2], 32'h100); end
        fetch(32'h0081_2183);
        tests++; if (op_o !== 7'h03 || funct3_o !== 3'h2) begin fails++; $display("FAIL lw_op: got op=%h f3=%h expected op=03 f3=2", op_o, funct3_o); end
        decode();
        exec_i();
        ctrl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        ReadData_i = 32'hDEAD_BEEF;
        #1;
        tests++; if (Adr_o !== 32'h108) begin fails++; $display("FAIL lw_adr: got %h expected %h", Adr_o, 32'h108); end
        step();
        ctrl(0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);
        ReadData_i = 32'h0;
        step();
        tests++; if (dut.r_rf[3] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_rf3: got %h expected %h", dut.r_rf[3], 32'hDEAD_BEEF); end
    endtask

    task automatic test_beq();
        run_addi(32'h0070_0213);
        run_addi(32'h0070_0293);
        for (int i = 0; i < 16 && Adr_o !== 32'h20; i++) fetch(32'h0000_0013);
        tests++; if (Adr_o !== 32'h20) begin fails++; $display("FAIL beq_pc20: got %h expected %h", Adr_o, 32'h20); end
        fetch(32'hFE52_0CE3);
        tests++; if (op_o !== 7'h63 || funct7_o !== 1'b1) begin fails++; $display("FAIL beq_op: got op=%h f7=%b expected op=63 f7=1", op_o, funct7_o); end
        ctrl(0, 1, 0, 0, 2'b00, 2'b00, 2'b11, 3'b000, 3'b000); #1;
        tests++; if (Adr_o !== 32'hFFFF_FFE5) begin fails++; $display("FAIL imm_i: got %h expected %h", Adr_o, 32'hFFFF_FFE5); end
        ImmSrc_i = 3'b001; #1;
        tests++; if (Adr_o !== 32'hFFFF_FFF9) begin fails++; $display("FAIL imm_s: got %h expected %h", Adr_o, 32'hFFFF_FFF9); end
        ImmSrc_i = 3'b010; #1;
        tests++; if (Adr_o !== 32'hFFFF_FFF8) begin fails++; $display("FAIL imm_b: got %h expected %h", Adr_o, 32'hFFFF_FFF8); end
        ImmSrc_i = 3'b011; #1;
        tests++; if (Adr_o !== 32'hFFF2_0FE4) begin fails++; $display("FAIL imm_j: got %h expected %h", Adr_o, 32'hFFF2_0FE4); end
        ImmSrc_i = 3'b100; #1;
        tests++; if (Adr_o !== 32'hFE52_0000) begin fails++; $display("FAIL imm_u: got %h expected %h", Adr_o, 32'hFE52_0000); end
        ImmSrc_i = 3'b101; #1;
        tests++; if (Adr_o !== 32'h0) begin fails++; $display("FAIL imm_undef: got %h expected %h", Adr_o, 32'h0); end
        decode();
        tests++; if (WriteData_o !== 32'h7) begin fails++; $display("FAIL beq_b: got %h expected %h", WriteData_o, 32'h7); end
        ctrl(1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000);
        #1;
        tests++; if (zero_o !== 1'b1) begin fails++; $display("FAIL beq_zero: got %b expected 1", zero_o); end
        step();
        ctrl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        #1;
        tests++; if (Adr_o !== 32'h18) begin fails++; $display("FAIL beq_target: got %h expected %h", Adr_o, 32'h18); end
    endtask

    task automatic test_x0();
        run_addi(32'h0090_0013);
        tests++; if (dut.r_rf[0] !== 32'h0) begin fails++; $display("FAIL x0_rf0: got %h expected %h", dut.r_rf[0], 32'h0); end
        ctrl(0, 1, 0, 0, 2'b10, 2'b10, 2'b10, 3'b000, 3'b000);
        step();
        tests++; if (Adr_o !== 32'h4) begin fails++; $display("FAIL x0_a: got %h expected %h", Adr_o, 32'h4); end
    endtask

    task automatic test_slt();
        fetch(32'h8000_03B7);
        decode();
        ctrl(0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 3'b000, 3'b100);
        step();
        run_addi(32'h0010_0413);
        fetch(32'h0083_A4B3);
        decode();
        ctrl(0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b101, 3'b000);
        #1;
        tests++; if (Adr_o !== 32'h1 || zero_o !== 1'b0) begin fails++; $display("FAIL slt_ovf1: got %h z=%b expected 00000001 z=0", Adr_o, zero_o); end
        fetch(32'h0074_24B3);
        decode();
        ctrl(0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b101, 3'b000);
        #1;
        tests++; if (Adr_o !== 32'h0 || zero_o !== 1'b1) begin fails++; $display("FAIL slt_ovf0: got %h z=%b expected 00000000 z=1", Adr_o, zero_o); end
        ALUControl_i = 3'b001; #1;
        tests++; if (Adr_o !== 32'h8000_0001) begin fails++; $display("FAIL alu_sub: got %h expected %h", Adr_o, 32'h8000_0001); end
        ALUControl_i = 3'b011; #1;
        tests++; if (Adr_o !== 32'h8000_0001) begin fails++; $display("FAIL alu_or: got %h expected %h", Adr_o, 32'h8000_0001); end
        ALUControl_i = 3'b010; #1;
        tests++; if (Adr_o !== 32'h0 || zero_o !== 1'b1) begin fails++; $display("FAIL alu_and: got %h z=%b expected 0 z=1", Adr_o, zero_o); end
        ALUControl_i = 3'b000; #1;
        tests++; if (Adr_o !== 32'h8000_0001) begin fails++; $display("FAIL alu_add: got %h expected %h", Adr_o, 32'h8000_0001); end
        ALUControl_i = 3'b111; #1;
        tests++; if (Adr_o !== 32'h0 || zero_o !== 1'b1) begin fails++; $display("FAIL alu_undef: got %h z=%b expected 0 z=1", Adr_o, zero_o); end
    endtask

    task automatic test_pc_wrap();
        fetch(32'hFFC0_0013);
        ctrl(1, 0, 0, 0, 2'b00, 2'b00, 2'b11, 3'b000, 3'b000);
        step();
        ctrl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        #1;
        tests++; if (Adr_o !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pre: got %h expected %h", Adr_o, 32'hFFFF_FFFC); end
        fetch(32'h0000_0013);
        tests++; if (Adr_o !== 32'h0) begin fails++; $display("FAIL wrap_pc: got %h expected %h", Adr_o, 32'h0); end
    endtask

    task automatic test_lui_reset();
        fetch(32'h1234_5337);
        decode();
        ctrl(0, 1, 0, 1, 2'b00, 2'b00, 2'b11, 3'b000, 3'b100);
        #1;
        tests++; if (Adr_o !== 32'h1234_5000) begin fails++; $display("FAIL lui_result: got %h expected %h", Adr_o, 32'h1234_5000); end
        step();
        tests++; if (dut.r_rf[6] !== 32'h1234_5000) begin fails++; $display("FAIL lui_rf6: got %h expected %h", dut.r_rf[6], 32'h1234_5000); end
        ctrl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        #1;
        tests++; if (Adr_o === 32'h0) begin fails++; $display("FAIL lui_pc_nonzero: got %h expected nonzero", Adr_o); end
        reset = 1'b0;
        #1;
        tests++; if (Adr_o !== 32'h0) begin fails++; $display("FAIL async_pc: got %h expected %h", Adr_o, 32'h0); end
        tests++; if (dut.r_rf[6] !== 32'h0) begin fails++; $display("FAIL async_rf6: got %h expected %h", dut.r_rf[6], 32'h0); end
        tests++; if (op_o !== 7'h0) begin fails++; $display("FAIL async_op: got %h expected %h", op_o, 7'h0); end
        step();
        reset = 1'b1;
        fetch(32'h0000_0013);
        tests++; if (Adr_o !== 32'h4 || dut.r_oldpc !== 32'h0) begin fails++; $display("FAIL refetch: got pc=%h oldpc=%h expected pc=4 oldpc=0", Adr_o, dut.r_oldpc); end
    endtask

    initial begin
        test_reset();
        step();
        test_fetch_addi();
        test_no_bypass();
        test_lw();
        test_beq();
        test_x0();
        test_slt();
        test_pc_wrap();
        test_lui_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ucsbece154a_datapath.md
Name: ucsbece154a_datapath

Overview:
Multicycle RV32I datapath that consumes the per-cycle control word from the main controller FSM and returns the decoded instruction fields and the ALU zero flag. It holds the architectural state and the non-architectural stage registers: PC, OldPC, IR, Data, A, B, ALUOut and a 32x32 register file. It also contains the ALU, the immediate extender and all source and result muxes. It sits between the controller and a unified external instruction/data memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, data and address width; only 32 is supported

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
PCWrite_i  in  1  load PC from Result
AdrSrc_i  in  1  memory address select: 0=PC, 1=Result
IRWrite_i  in  1  load IR from ReadData and OldPC from PC
RegWrite_i  in  1  write Result to register rd
ALUSrcA_i  in  2  00=PC, 01=OldPC, 10=A
ALUSrcB_i  in  2  00=B, 01=ImmExt, 10=constant 4
ResultSrc_i  in  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
ALUControl_i  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc_i  in  3  000 I, 001 S, 010 B, 011 J, 100 U
ReadData_i  in  32  memory read data, combinational from Adr_o
Adr_o  out  32  memory address
WriteData_o  out  32  memory write data, equals register B
op_o  out  7  IR[6:0]
funct3_o  out  3  IR[14:12]
funct7_o  out  1  IR[30]
zero_o  out  1  ALUResult == 0, combinational

Behaviour:
- Reset (reset=0, asynchronous): PC=RESET_PC; OldPC, IR, Data, A, B, ALUOut=0; all 32 registers=0.
- With IR=0 after reset: op_o=0, funct3_o=0, funct7_o=0.
- After reset, Adr_o=RESET_PC.
- Deassertion of reset takes effect at the next posedge.
- Registers updated every posedge, unconditionally:
  - Data <= ReadData_i
  - A <= RF[IR[19:15]]
  - B <= RF[IR[24:20]]
  - ALUOut <= ALUResult
- Enabled registers:
  - IRWrite_i=1: IR <= ReadData_i and OldPC <= PC, on the same edge.
  - PCWrite_i=1: PC <= Result. Otherwise PC holds.
- Result mux is combinational per ResultSrc_i.
- Result feeds the PC, Adr_o (when AdrSrc_i=1) and the register-file write data.
- Register file:
  - Two combinational read ports; one write port on posedge.
  - Write address is IR[11:7].
  - A write with rd=0 is discarded; RF[0] always reads 0.
  - A read in the same cycle as a write to the same register returns the old value; there is no bypass.
- Immediate extender (combinational, from IR):
  - I: sext(IR[31:20])
  - S: sext({IR[31:25],IR[11:7]})
  - B: sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0})
  - J: sext({IR[31],IR[19:12],IR[20],IR[30:21],1'b0})
  - U: {IR[31:12],12'b0}
  - Undefined ImmSrc_i: 32'b0.
- ALU:
  - add and sub are modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0.
  - slt is a signed compare that stays correct under subtraction overflow; result is 32'd1 or 32'd0.
  - Undefined ALUControl_i codes give ALUResult=0, so zero_o=1.
- Control inputs are sampled only on posedge; the controller drives them from flops, so no input path is combinational to state.
- Only the combinational paths ReadData_i→IR/Data, Adr_o and zero_o are seen by the controller within a cycle.
- Reset asserted mid-instruction: all state clears immediately; the next fetch after release uses address RESET_PC.

Test Plan:
- Reset then fetch: hold reset=0 and load IR with junk → all regs 0, Adr_o=0. Release reset, ReadData_i=32'h00500093 (addi x1,x0,5), one Fetch cycle (IRWrite, PCWrite, ALUSrcA=00, ALUSrcB=10, ResultSrc=10) → PC=4, IR=00500093, op_o=7'h13. Decode, then ExecuteI, then ALUWB → RF[1]=5.
- lw: RF[2]=32'h100, IR=lw x3,8(x2). MemAdr computes 108; MemRead with AdrSrc=1, ResultSrc=00 → Adr_o=32'h108. ReadData_i=32'hDEADBEEF, then MemWB with ResultSrc=01 → RF[3]=DEADBEEF.
- beq taken: RF[4]=RF[5]=7, OldPC=32'h20, B-imm=-8. Decode puts 0x18 in ALUOut. In the BEQ state zero_o=1 and PCWrite with ResultSrc=00 → PC=32'h18.
- x0 write: addi x0,x0,9 through ALUWB → RF[0] reads 0 and A=0 on the next cycle.
- slt overflow: A=32'h8000_0000, B=1, ALUControl=101 → ALUResult=1, zero_o=0. A=1, B=32'h8000_0000 → ALUResult=0, zero_o=1.
- lui and reset mid-operation: IR=lui x6,0x12345, ResultSrc=11, RegWrite → RF[6]=32'h12345000. Then assert reset asynchronously between edges → PC=RESET_PC and RF[6]=0 immediately, with no clock.
